// File: rtl/instr_decoder.sv
// Instruction decoder: captures a 64-bit instruction word, dispatches it to the
// load/compute/store engines, waits for that engine's completion and retires it.
module instr_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instruction_enable,
  input  logic [63:0] ctr,
  output logic        instr_exe_state,
  output logic        ld_start,
  output logic        ld_is_weight,
  output logic [3:0]  ld_buf_id,
  output logic [23:0] ld_ext_addr,
  output logic [15:0] ld_len,
  output logic        comp_start,
  output logic [3:0]  comp_buf_id,
  output logic [15:0] comp_param,
  output logic        st_start,
  output logic [3:0]  st_buf_id,
  output logic [23:0] st_ext_addr,
  output logic [15:0] st_len,
  input  logic        ld_done,
  input  logic        comp_done,
  input  logic        st_done,
  output logic        busy,
  output logic [15:0] instr_cnt,
  output logic        end_flag,
  output logic        illegal_op,
  output logic        overrun
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LD   = 4'd1;
  localparam logic [3:0] OP_LW   = 4'd2;
  localparam logic [3:0] OP_CONV = 4'd3;
  localparam logic [3:0] OP_SAVE = 4'd4;
  localparam logic [3:0] OP_END  = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_RETIRE
  } state_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_LW);
  endfunction

  function automatic logic is_engine_op(input logic [3:0] op);
    return is_load(op) || (op == OP_CONV) || (op == OP_SAVE);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return is_engine_op(op) || (op == OP_NOP) || (op == OP_END);
  endfunction

  state_t      state_q, state_d;
  logic [63:0] instr_q, instr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        end_q, end_d;
  logic        illegal_q, illegal_d;
  logic        overrun_q, overrun_d;

  logic        ld_w_q, ld_w_d;
  logic [3:0]  ld_buf_q, ld_buf_d;
  logic [23:0] ld_addr_q, ld_addr_d;
  logic [15:0] ld_len_q, ld_len_d;
  logic [3:0]  comp_buf_q, comp_buf_d;
  logic [15:0] comp_param_q, comp_param_d;
  logic [3:0]  st_buf_q, st_buf_d;
  logic [23:0] st_addr_q, st_addr_d;
  logic [15:0] st_len_q, st_len_d;

  logic [3:0]  f_op;
  logic [3:0]  f_buf;
  logic [23:0] f_addr;
  logic [15:0] f_len;
  logic [15:0] f_param;
  logic        done_sel;

  assign f_op    = instr_q[63:60];
  assign f_buf   = instr_q[59:56];
  assign f_addr  = instr_q[55:32];
  assign f_len   = instr_q[31:16];
  assign f_param = instr_q[15:0];

  // Only the completion of the engine that was actually issued is honoured.
  always_comb begin
    done_sel = 1'b0;
    if (is_load(f_op))          done_sel = ld_done;
    else if (f_op == OP_CONV)   done_sel = comp_done;
    else if (f_op == OP_SAVE)   done_sel = st_done;
  end

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    cnt_d        = cnt_q;
    end_d        = end_q;
    illegal_d    = illegal_q;
    overrun_d    = overrun_q | (instruction_enable && (state_q != S_IDLE));
    ld_w_d       = ld_w_q;
    ld_buf_d     = ld_buf_q;
    ld_addr_d    = ld_addr_q;
    ld_len_d     = ld_len_q;
    comp_buf_d   = comp_buf_q;
    comp_param_d = comp_param_q;
    st_buf_d     = st_buf_q;
    st_addr_d    = st_addr_q;
    st_len_d     = st_len_q;

    unique case (state_q)
      S_IDLE: begin
        if (instruction_enable) begin
          instr_d = ctr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_load(f_op)) begin
          ld_w_d    = (f_op == OP_LW);
          ld_buf_d  = f_buf;
          ld_addr_d = f_addr;
          ld_len_d  = f_len;
        end
        if (f_op == OP_CONV) begin
          comp_buf_d   = f_buf;
          comp_param_d = f_param;
        end
        if (f_op == OP_SAVE) begin
          st_buf_d  = f_buf;
          st_addr_d = f_addr;
          st_len_d  = f_len;
        end
        if (f_op == OP_END)  end_d     = 1'b1;
        if (!is_legal(f_op)) illegal_d = 1'b1;
        state_d = is_engine_op(f_op) ? S_ISSUE : S_RETIRE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (done_sel) state_d = S_RETIRE;
      end
      S_RETIRE: begin
        cnt_d   = cnt_q + 16'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      instr_q      <= '0;
      cnt_q        <= '0;
      end_q        <= 1'b0;
      illegal_q    <= 1'b0;
      overrun_q    <= 1'b0;
      ld_w_q       <= 1'b0;
      ld_buf_q     <= '0;
      ld_addr_q    <= '0;
      ld_len_q     <= '0;
      comp_buf_q   <= '0;
      comp_param_q <= '0;
      st_buf_q     <= '0;
      st_addr_q    <= '0;
      st_len_q     <= '0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      cnt_q        <= cnt_d;
      end_q        <= end_d;
      illegal_q    <= illegal_d;
      overrun_q    <= overrun_d;
      ld_w_q       <= ld_w_d;
      ld_buf_q     <= ld_buf_d;
      ld_addr_q    <= ld_addr_d;
      ld_len_q     <= ld_len_d;
      comp_buf_q   <= comp_buf_d;
      comp_param_q <= comp_param_d;
      st_buf_q     <= st_buf_d;
      st_addr_q    <= st_addr_d;
      st_len_q     <= st_len_d;
    end
  end

  // Parameter outputs follow the next-state values so they are already valid
  // during DECODE, and equal the held registers in every other state.
  assign ld_is_weight = ld_w_d;
  assign ld_buf_id    = ld_buf_d;
  assign ld_ext_addr  = ld_addr_d;
  assign ld_len       = ld_len_d;
  assign comp_buf_id  = comp_buf_d;
  assign comp_param   = comp_param_d;
  assign st_buf_id    = st_buf_d;
  assign st_ext_addr  = st_addr_d;
  assign st_len       = st_len_d;

  assign ld_start        = (state_q == S_ISSUE) && is_load(f_op);
  assign comp_start      = (state_q == S_ISSUE) && (f_op == OP_CONV);
  assign st_start        = (state_q == S_ISSUE) && (f_op == OP_SAVE);
  assign instr_exe_state = (state_q == S_RETIRE);
  assign busy            = (state_q != S_IDLE);
  assign instr_cnt       = cnt_q;
  assign end_flag        = end_q;
  assign illegal_op      = illegal_q;
  assign overrun         = overrun_q;

endmodule
